hmmm_mem_arbiter: RTL and testbench

Arbitrates the single-port Hmmm program/data memory (256 x 16) between two requesters: the Hmmm core (instruction fetch, load, store) and the management SoC Wishbone slave port (program load and debug readback).
Sits in the user project wrapper between the core, the Wishbone slave decode and the memory macro.
Wishbone gets fixed priority, with an anti-starvation limit so the core always progresses.

---
 rtl/hmmm_pkg.sv | 25 ++
 rtl/hmmm_mem_arbiter.sv | 116 +++++++++++
 tb/tb_hmmm_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hmmm_pkg.sv
// Shared types and constants for the Hmmm memory subsystem.
package hmmm_pkg;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    typedef logic [DW-1:0] hmmm_word_t;
    typedef logic [AW-1:0] hmmm_addr_t;

    // Access captured at grant time and replayed onto the memory port.
    typedef struct packed {
        logic       we;
        hmmm_addr_t addr;
        hmmm_word_t wdata;
    } mem_req_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_WB,
        ACK_WB,
        ISSUE_CORE,
        ACK_CORE
    } arb_state_t;

endpackage

// File: rtl/hmmm_mem_arbiter.sv
// Shares the single-port Hmmm memory between the core and the Wishbone slave.
// Wishbone has fixed priority, bounded by a run limit so the core always progresses.
module hmmm_mem_arbiter
    import hmmm_pkg::*;
#(
    parameter int unsigned WB_MAX_RUN = 4
) (
    input  logic          clock,
    input  logic          resetb,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant_wb
);

    localparam int unsigned RW = $clog2(WB_MAX_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(WB_MAX_RUN);

    arb_state_t state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    mem_req_t   req_q, req_d;
    logic       grant_wb_q, grant_wb_d;
    hmmm_word_t core_rdata_q, core_rdata_d;
    logic       wb_valid;
    logic       issuing;

    // Byte-lane and high address bits are intentionally dropped.
    logic unused_ok;
    assign unused_ok = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0], wbs_dat_i[31:DW]};

    assign wbs_ack_o = (state_q == ACK_WB);
    assign core_ack  = (state_q == ACK_CORE);
    assign wb_valid  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign issuing   = (state_q == ISSUE_WB) || (state_q == ISSUE_CORE);

    assign mem_en    = issuing;
    assign mem_we    = issuing & req_q.we;
    assign mem_addr  = issuing ? req_q.addr  : '0;
    assign mem_wdata = issuing ? req_q.wdata : '0;

    // Read data arrives in the ack cycle; core keeps its last read value across writes.
    assign wbs_dat_o  = (wbs_ack_o && !req_q.we) ? 32'(mem_rdata) : '0;
    assign core_rdata = (core_ack && !req_q.we) ? mem_rdata : core_rdata_q;
    assign grant_wb   = grant_wb_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            run_q        <= '0;
            req_q        <= '0;
            grant_wb_q   <= 1'b0;
            core_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            req_q        <= req_d;
            grant_wb_q   <= grant_wb_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        req_d        = req_q;
        grant_wb_d   = grant_wb_q;
        core_rdata_d = core_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (wb_valid && (!core_req || (run_q < RUN_MAX))) begin
                    state_d     = ISSUE_WB;
                    run_d       = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
                    req_d.we    = wbs_we_i;
                    req_d.addr  = wbs_adr_i[AW+1:2];
                    req_d.wdata = wbs_dat_i[DW-1:0];
                    grant_wb_d  = 1'b1;
                end else if (core_req) begin
                    state_d     = ISSUE_CORE;
                    run_d       = '0;
                    req_d.we    = core_we;
                    req_d.addr  = core_addr;
                    req_d.wdata = core_wdata;
                    grant_wb_d  = 1'b0;
                end else begin
                    run_d = '0;
                end
            end
            ISSUE_WB:   state_d = ACK_WB;
            ACK_WB:     state_d = IDLE;
            ISSUE_CORE: state_d = ACK_CORE;
            ACK_CORE: begin
                state_d = IDLE;
                if (!req_q.we) begin
                    core_rdata_d = mem_rdata;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hmmm_mem_arbiter.sv
// Bench for hmmm_mem_arbiter: vector table plus scoreboard queues, and
// hand-written sequences for priority, fairness and mid-access reset.
module tb_hmmm_mem_arbiter;

    logic        clock;
    logic        resetb;
    logic        core_req, core_we;
    logic [7:0]  core_addr;
    logic [15:0] core_wdata;
    logic        core_ack;
    logic [15:0] core_rdata;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        grant_wb;

    hmmm_mem_arbiter dut (
        .clock(clock), .resetb(resetb),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant_wb(grant_wb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memory macro model.
    logic [15:0] mem [256];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic        is_wb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [7:0]  exp_addr;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } mem_exp_t;

    mem_exp_t    mem_q[$];
    logic [31:0] wb_q[$];
    logic [15:0] core_q[$];
    bit          sb_on = 1'b1;
    int          checks = 0;
    int          passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: pops expectations as the DUT issues and acknowledges.
    always @(negedge clock) begin
        if (sb_on) begin
            if (mem_en) begin
                if (mem_q.size() == 0) check("mem_en_unexpected", 32'(mem_en), 32'h0);
                else check("mem_issue", 32'({mem_we, mem_addr, mem_wdata}), 32'(mem_q.pop_front()));
            end
            if (wbs_ack_o) begin
                if (wb_q.size() == 0) check("wbs_ack_unexpected", 32'(wbs_ack_o), 32'h0);
                else check("wbs_dat_o", wbs_dat_o, wb_q.pop_front());
            end
            if (core_ack) begin
                if (core_q.size() == 0) check("core_ack_unexpected", 32'(core_ack), 32'h0);
                else check("core_rdata", 32'(core_rdata), 32'(core_q.pop_front()));
            end
        end
    end

    task automatic drop_all();
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = '0; wbs_dat_i = '0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit seen;
        mem_exp_t me;
        me.we = v.we; me.addr = v.exp_addr; me.wdata = v.wdata[15:0];
        mem_q.push_back(me);
        if (v.is_wb) wb_q.push_back(v.we ? 32'h0 : {16'h0, v.exp_rdata});
        else         core_q.push_back(v.exp_rdata);
        @(posedge clock); #1;
        if (v.is_wb) begin
            wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = v.we; wbs_adr_i = v.adr; wbs_dat_i = v.wdata;
        end else begin
            core_req = 1; core_we = v.we; core_addr = v.adr[7:0]; core_wdata = v.wdata[15:0];
        end
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clock);
            lat++;
            seen = v.is_wb ? wbs_ack_o : core_ack;
        end
        check($sformatf("latency[%0d]", idx), 32'(lat), 32'd3);
        @(posedge clock); #1;
        drop_all();
    endtask

    vec_t vecs[11];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wb_cyc, core_cyc, issues, last_core;
        bit wb_done, core_done, hit;
        vec_t rv;
        mem_exp_t me;

        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_BEEF, 8'h02, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         8'h02, 16'hBEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_1234, 8'h05, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0005, 32'h0,         8'h05, 16'h1234};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_A5A5, 8'h01, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,         8'h01, 16'hA5A5};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0001, 32'h0000_0F0F, 8'h01, 16'h1234};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0007, 32'h0,         8'h01, 16'h0F0F};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0002, 32'h0,         8'h02, 16'hBEEF};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_5555, 8'hFF, 16'h0000};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0,         8'hFF, 16'h5555};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        drop_all();
        resetb = 0;
        #2;
        check("rst_core_ack",   32'(core_ack),   32'h0);
        check("rst_core_rdata", 32'(core_rdata), 32'h0);
        check("rst_wbs_ack_o",  32'(wbs_ack_o),  32'h0);
        check("rst_wbs_dat_o",  wbs_dat_o,       32'h0);
        check("rst_mem_bus",    32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'h0);
        check("rst_grant_wb",   32'(grant_wb),   32'h0);
        repeat (2) @(negedge clock);
        resetb = 1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Simultaneous requests: Wishbone first, then core.
        me = '{1'b0, 8'h02, 16'h0}; mem_q.push_back(me);
        me = '{1'b0, 8'h05, 16'h0}; mem_q.push_back(me);
        wb_q.push_back(32'h0000_BEEF);
        core_q.push_back(16'h1234);
        @(posedge clock); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h8;
        core_req = 1; core_we = 0; core_addr = 8'h05;
        wb_cyc = 0; core_cyc = 0; wb_done = 0; core_done = 0; hit = 0;
        for (int c = 1; c <= 20 && !(wb_done && core_done); c++) begin
            @(negedge clock);
            if (mem_en && !hit) begin
                check("sim_first_grant_wb", 32'(grant_wb), 32'h1);
                hit = 1;
            end
            if (wbs_ack_o) begin wb_cyc = c; wb_done = 1; end
            if (core_ack) begin core_cyc = c; core_done = 1; end
            @(posedge clock); #1;
            if (wb_done)   begin wbs_cyc_i = 0; wbs_stb_i = 0; end
            if (core_done) core_req = 0;
        end
        check("sim_wb_ack_cycle",   32'(wb_cyc),   32'd3);
        check("sim_core_ack_cycle", 32'(core_cyc), 32'd6);
        drop_all();

        // Both held continuously: WB,WB,WB,WB,CORE repeating.
        repeat (2) @(negedge clock);
        sb_on = 0;
        @(posedge clock); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h8;
        core_req = 1; core_we = 0; core_addr = 8'h05;
        issues = 0; last_core = 0;
        for (int c = 1; c <= 60 && issues < 15; c++) begin
            @(negedge clock);
            if (mem_en) begin
                check($sformatf("fair_grant[%0d]", issues), 32'(grant_wb),
                      (issues % 5 == 4) ? 32'h0 : 32'h1);
                issues++;
            end
            if (core_ack) begin
                check("core_wait_le_15", 32'((c - last_core) <= 15), 32'h1);
                last_core = c;
            end
        end
        check("fair_issue_count", 32'(issues), 32'd15);
        @(posedge clock); #1;
        drop_all();
        repeat (3) @(negedge clock);

        // Reset pulsed during ISSUE_WB abandons the write.
        @(posedge clock); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h80; wbs_dat_i = 32'h7777;
        hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clock);
            hit = mem_en;
        end
        check("rst_issue_seen", 32'(hit), 32'h1);
        resetb = 0;
        #1;
        check("midrst_mem_bus",  32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'h0);
        check("midrst_acks",     32'({wbs_ack_o, core_ack}), 32'h0);
        check("midrst_grant_wb", 32'(grant_wb), 32'h0);
        check("midrst_wbs_dat",  wbs_dat_o, 32'h0);
        @(posedge clock); #1;
        drop_all();
        @(negedge clock);
        resetb = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check("post_rst_quiet", 32'({wbs_ack_o, core_ack, mem_en}), 32'h0);
        end
        sb_on = 1;
        rv = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 8'h20, 16'h0000};
        run_vec(rv, 99);

        repeat (3) @(negedge clock);
        check("mem_q_empty",  32'(mem_q.size()),  32'h0);
        check("wb_q_empty",   32'(wb_q.size()),   32'h0);
        check("core_q_empty", 32'(core_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
